core_launcher: RTL and testbench

//  Host-side initiator for the single-cycle core's req/done handshake. Preloads data memory from an

---
 rtl/core_launch_pkg.sv | 18 +
 rtl/launch_out_reg.sv | 34 +++
 rtl/core_launcher.sv | 198 +++++++++++++++++++
 tb/tb_core_launcher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_launch_pkg.sv
// rtl/core_launch_pkg.sv - shared state type and default widths for the core launcher
package core_launch_pkg;

    localparam int DEF_ADDR_W         = 8;
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_CNT_W          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        RUN,
        READ,
        FINISH
    } launcher_state_t;

endpackage

// File: rtl/launch_out_reg.sv
// rtl/launch_out_reg.sv - one-entry valid/ready output register for the result stream
//
// Purpose: holds one result byte; captures on load, holds while the consumer stalls,
//          drains on acceptance.
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   load, load_data     capture request and byte (caller guarantees empty or draining)
//   out_valid, out_data registered stream output
//   out_ready           consumer ready
module launch_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/core_launcher.sv
// rtl/core_launcher.sv - host-side preload / launch / result-readout initiator for the core
//
// Purpose: preloads data memory from an input byte stream, raises core_req, waits for a
//          rising core_done (with timeout), then streams results out of data memory.
// Ports:
//   clk, reset                          clock and asynchronous active-low reset
//   start, load_base/len, res_base/len  launch request and regions (captured in IDLE)
//   in_valid, in_data, in_ready         preload byte stream
//   out_valid, out_data, out_ready      result byte stream
//   core_req, core_done                 core handshake
//   mem_wr_en, mem_addr, mem_wr_data,
//   mem_rd_data                         data-memory port (combinational read)
//   busy, finished, timeout, cycle_count status
module core_launcher
    import core_launch_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W-1:0] load_len,
    input  logic [ADDR_W-1:0] res_base,
    input  logic [ADDR_W-1:0] res_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              core_req,
    input  logic              core_done,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              finished,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    // cycle_count holds this value during the last RUN cycle before an abort
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    launcher_state_t state, state_next;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] load_left;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] rd_left;   // bytes still to fetch into the output register
    logic [ADDR_W-1:0] acc_left;  // bytes still to be accepted by the consumer
    logic              done_q;

    logic start_acc;
    logic load_xfer;
    logic done_edge;
    logic run_expire;
    logic out_accept;
    logic out_load;

    assign start_acc  = (state == IDLE) && start;
    assign load_xfer  = (state == LOAD) && in_valid;
    assign done_edge  = !done_q && core_done;
    assign run_expire = (cycle_count == RUN_LAST);
    assign out_accept = out_valid && out_ready;
    // fetch the next byte whenever the output register is empty or draining this cycle
    assign out_load   = (state == READ) && (rd_left != '0) && (!out_valid || out_ready);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        core_req    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (load_len != '0) ? LOAD : LAUNCH;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                mem_addr = wr_ptr;
                if (in_valid) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = in_data;
                    if (load_left == ADDR_W'(1)) begin
                        state_next = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                core_req   = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                core_req = 1'b1;
                // a completion on the final allowed cycle wins over the abort
                if (done_edge) begin
                    state_next = (acc_left != '0) ? READ : FINISH;
                end else if (run_expire) begin
                    state_next = FINISH;
                end
            end
            READ: begin
                mem_addr = rd_ptr;
                if (out_accept && (acc_left == ADDR_W'(1))) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            load_left   <= '0;
            rd_ptr      <= '0;
            rd_left     <= '0;
            acc_left    <= '0;
            done_q      <= 1'b0;
            finished    <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
        end else begin
            if (start_acc) begin
                wr_ptr      <= load_base;
                load_left   <= load_len;
                rd_ptr      <= res_base;
                rd_left     <= res_len;
                acc_left    <= res_len;
                finished    <= 1'b0;
                timeout     <= 1'b0;
                cycle_count <= '0;
            end
            if (load_xfer) begin
                wr_ptr    <= wr_ptr + ADDR_W'(1);
                load_left <= load_left - ADDR_W'(1);
            end
            // done is sampled from LAUNCH on so a level already high at launch is not an edge
            if ((state == LAUNCH) || (state == RUN)) begin
                done_q <= core_done;
            end
            if (state == RUN) begin
                if (cycle_count != '1) begin
                    cycle_count <= cycle_count + CNT_W'(1);
                end
                if (!done_edge && run_expire) begin
                    timeout <= 1'b1;
                end
            end
            if (out_load) begin
                rd_ptr  <= rd_ptr + ADDR_W'(1);
                rd_left <= rd_left - ADDR_W'(1);
            end
            if ((state == READ) && out_accept) begin
                acc_left <= acc_left - ADDR_W'(1);
            end
            if (state == FINISH) begin
                finished <= 1'b1;
            end
        end
    end

    launch_out_reg #(
        .DATA_W(DATA_W)
    ) u_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (out_load),
        .load_data(mem_rd_data),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_core_launcher.sv
// tb/tb_core_launcher.sv - randomized self-checking bench for core_launcher
module tb_core_launcher;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  load_base = '0, load_len = '0, res_base = '0, res_len = '0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready = 1'b0;
    logic        core_req;
    logic        core_done = 1'b0;
    logic        mem_wr_en;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wr_data;
    logic [7:0]  mem_rd_data;
    logic        busy, finished, timeout;
    logic [15:0] cycle_count;

    core_launcher #(
        .ADDR_W(8), .DATA_W(8), .CNT_W(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .load_base(load_base), .load_len(load_len), .res_base(res_base), .res_len(res_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_req(core_req), .core_done(core_done),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data),
        .busy(busy), .finished(finished), .timeout(timeout), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // data memory attached to the DUT, plus the reference image of what it should hold
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic       seed_mem = 1'b0;
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) begin
        if (seed_mem) mem <= ref_mem;
        else if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    int n_checks = 0;
    int n_pass   = 0;

    bit         sched [64];   // core_done level for each req-high cycle (index 0 = LAUNCH)
    logic [7:0] ldata [$];
    int         ready_pat [$];
    int         valid_pct = 100;
    logic [7:0] lb_v, ll_v, rb_v, rl_v;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // done is high for the first h req cycles, low for the next l, then high forever
    task automatic set_sched(input int h, input int l);
        for (int j = 0; j < 64; j++) sched[j] = (j < h) ? 1'b1 : ((j < h + l) ? 1'b0 : 1'b1);
    endtask

    task automatic do_launch(input logic [7:0] lb, input logic [7:0] ll,
                             input logic [7:0] rb, input logic [7:0] rl);
        int         exp_cnt, li, jreq, req_cycles, vcount, bad;
        bit         exp_to, ended, prev_stall;
        logic [7:0] prev_data;
        logic [7:0] got [$];
        logic [7:0] exp_q [$];
        // reference: first rising edge of done seen after LAUNCH, else abort at TO
        exp_to = 1'b1;
        exp_cnt = TO;
        for (int j = 1; j <= TO; j++) begin
            if (exp_to && !sched[j-1] && sched[j]) begin
                exp_cnt = j;
                exp_to = 1'b0;
            end
        end
        for (int i = 0; i < int'(ll); i++) ref_mem[8'(lb + i)] = ldata[i];
        if (!exp_to) for (int i = 0; i < int'(rl); i++) exp_q.push_back(ref_mem[8'(rb + i)]);
        li = 0; jreq = 0; req_cycles = 0; vcount = 0; prev_stall = 1'b0; prev_data = '0;

        @(negedge clk);
        load_base = lb; load_len = ll; res_base = rb; res_len = rl;
        start = 1'b1; core_done = sched[0]; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("finished_cleared", finished, 0);
        check("timeout_cleared", timeout, 0);
        check("count_cleared", cycle_count, 0);

        ended = 1'b0;
        for (int cyc = 0; cyc < 600 && !ended; cyc++) begin
            if (!busy) begin
                ended = 1'b1;
            end else begin
                if (core_req) begin
                    core_done = sched[jreq];
                    jreq++;
                    req_cycles++;
                end else if (jreq > 0) begin
                    core_done = 1'b0;
                end
                if (prev_stall) begin
                    check("stall_hold_valid", out_valid, 1);
                    check("stall_hold_data", out_data, prev_data);
                end
                if (out_valid) vcount++;
                if (out_valid && ready_pat.size() > 0) out_ready = ready_pat.pop_front() != 0;
                else out_ready = ($urandom_range(0, 3) != 0);
                if (out_valid && out_ready) got.push_back(out_data);
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
                in_valid = ($urandom_range(0, 99) < valid_pct);
                in_data = (li < int'(ll)) ? ldata[li] : 8'($urandom);
                // start and region inputs while busy must be ignored
                start = ($urandom_range(0, 7) == 0);
                load_base = 8'($urandom); load_len = 8'($urandom);
                res_base = 8'($urandom); res_len = 8'($urandom);
                #1;
                if (in_ready && in_valid) begin
                    check("wr_en", mem_wr_en, 1);
                    check("wr_addr", mem_addr, 8'(lb + li));
                    check("wr_data", mem_wr_data, (li < int'(ll)) ? ldata[li] : 8'h00);
                    li++;
                end else begin
                    check("wr_idle", mem_wr_en, 0);
                end
                @(negedge clk);
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; core_done = 1'b0;
        check("launch_ends", busy, 0);
        check("finished", finished, 1);
        check("timeout", timeout, 32'(exp_to));
        check("cycle_count", cycle_count, exp_cnt);
        check("req_cycles", req_cycles, exp_cnt + 1);
        check("write_count", li, ll);
        check("out_len", got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) check("out_byte", got[i], exp_q[i]);
        if (exp_q.size() == 0) check("no_out_valid", vcount, 0);
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        check("mem_image", bad, 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'($urandom);
        seed_mem = 1'b1;
        @(negedge clk);
        seed_mem = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_req", core_req, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_wr_en", mem_wr_en, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_finished", finished, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", cycle_count, 0);
        reset = 1'b1;
        @(negedge clk);

        // basic preload / run / readout
        ldata = '{8'hAA, 8'h55, 8'h01};
        set_sched(0, 5); valid_pct = 100; ready_pat = '{1, 1, 1};
        do_launch(8'h10, 8'd3, 8'h10, 8'd3);
        // nothing to load or read
        ldata.delete(); set_sched(0, 3);
        do_launch(8'h00, 8'd0, 8'h00, 8'd0);
        // done stuck low -> abort
        ldata = '{8'h11, 8'h22}; set_sched(0, 64);
        do_launch(8'h30, 8'd2, 8'h30, 8'd2);
        // done already high at launch: must be seen low, then high
        ldata = '{8'h99}; set_sched(4, 2);
        do_launch(8'h20, 8'd1, 8'h20, 8'd1);
        // done stuck high -> abort
        set_sched(64, 0);
        do_launch(8'h24, 8'd1, 8'h24, 8'd1);
        // consumer stalls mid-stream
        ldata = '{8'hC1, 8'hC2, 8'hC3, 8'hC4}; set_sched(0, 2); ready_pat = '{1, 0, 0, 1};
        do_launch(8'h40, 8'd4, 8'h40, 8'd4);
        // regions wrapping past the top of memory
        ldata = '{8'hE0, 8'hE1, 8'hE2, 8'hE3}; set_sched(1, 3); ready_pat.delete();
        do_launch(8'hFE, 8'd4, 8'hFE, 8'd4);

        valid_pct = 60;
        for (int t = 0; t < 10; t++) begin
            lb_v = 8'($urandom); ll_v = 8'($urandom_range(0, 12));
            rb_v = ($urandom_range(0, 1) != 0) ? lb_v : 8'($urandom);
            rl_v = 8'($urandom_range(0, 12));
            ldata.delete();
            for (int i = 0; i < int'(ll_v); i++) ldata.push_back(8'($urandom));
            case ($urandom_range(0, 5))
                0: set_sched(0, 64);
                1: set_sched(64, 0);
                default: set_sched($urandom_range(0, 3), $urandom_range(1, 6));
            endcase
            do_launch(lb_v, ll_v, rb_v, rl_v);
        end

        // reset in the middle of RUN
        set_sched(0, 64);
        @(negedge clk);
        load_len = 8'd0; res_len = 8'd0; start = 1'b1; core_done = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 6; k++) @(negedge clk);
        check("midrun_req_before", core_req, 1);
        reset = 1'b0;
        #1;
        check("midrun_req", core_req, 0);
        check("midrun_busy", busy, 0);
        check("midrun_in_ready", in_ready, 0);
        check("midrun_count", cycle_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_idle", busy, 0);
        check("midrun_req_after", core_req, 0);

        // reset in the middle of LOAD with a byte being offered
        load_base = 8'h80; load_len = 8'd5; res_len = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h3C;
        #1;
        check("midload_in_ready_before", in_ready, 1);
        check("midload_wr_before", mem_wr_en, 1);
        reset = 1'b0;
        #1;
        check("midload_in_ready", in_ready, 0);
        check("midload_wr_en", mem_wr_en, 0);
        check("midload_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("midload_idle", busy, 0);
        check("midload_finished", finished, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
